// File: rtl/hamming_pkg.sv
// Shared definitions for the SECDED (8,4) Hamming encoder/decoder pair:
// codeword bit positions, injection FSM states and the encode function.
package hamming_pkg;

    localparam int unsigned P1_POS = 0;
    localparam int unsigned P2_POS = 1;
    localparam int unsigned D1_POS = 2;
    localparam int unsigned P3_POS = 3;
    localparam int unsigned D2_POS = 4;
    localparam int unsigned D3_POS = 5;
    localparam int unsigned D4_POS = 6;
    localparam int unsigned P4_POS = 7;

    typedef enum logic [0:0] {
        INJ_IDLE  = 1'b0,
        INJ_ARMED = 1'b1
    } inj_state_e;

    // Even parity over the seven inner codeword bits.
    function automatic logic overall_parity(input logic [6:0] bits);
        return ^bits;
    endfunction

    function automatic logic [7:0] hamming_encode(input logic [3:0] data);
        logic [7:0] cw;
        cw         = 8'h00;
        cw[D1_POS] = data[0];
        cw[D2_POS] = data[1];
        cw[D3_POS] = data[2];
        cw[D4_POS] = data[3];
        cw[P1_POS] = data[0] ^ data[1] ^ data[3];
        cw[P2_POS] = data[0] ^ data[2] ^ data[3];
        cw[P3_POS] = data[1] ^ data[2] ^ data[3];
        cw[P4_POS] = overall_parity(cw[6:0]);
        return cw;
    endfunction

endpackage

// File: rtl/hamming_sync_fifo.sv
// Synchronous FIFO with extra pointer bit for full/empty detection.
// Writes when full and reads when empty are ignored.
module hamming_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             wr_ok_s;
    logic             rd_ok_s;
    logic             full_s;
    logic             empty_s;

    // Full when pointers alias the same slot on different wraps.
    always_comb begin
        empty_s = (wr_ptr_r == rd_ptr_r);
        full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        wr_ok_s = wr_en && !full_s;
        rd_ok_s = rd_en && !empty_s;
    end

    // Storage write; entries are never modified after being written.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

    // Read/write pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

    assign rd_data = mem_r[rd_ptr_r[AW-1:0]];
    assign full    = full_s;
    assign empty   = empty_s;

endmodule

// File: rtl/hamming_encoder_stream.sv
// Streaming SECDED (8,4) encoder: valid/ready in, FIFO-buffered codewords out,
// with one-shot error-mask injection applied to the next accepted word.
module hamming_encoder_stream
    import hamming_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_data,
    input  logic             inj_arm,
    input  logic [7:0]       inj_mask,
    output logic             inj_pending,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [CNT_W-1:0] word_count
);

    inj_state_e       inj_state_r;
    inj_state_e       inj_state_nxt_s;
    logic [7:0]       mask_r;
    logic [7:0]       mask_nxt_s;
    logic             apply_s;
    logic [CNT_W-1:0] count_r;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic [7:0]       code_s;
    logic [7:0]       head_s;

    hamming_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_s),
        .wr_data (code_s),
        .rd_en   (pop_s),
        .rd_data (head_s),
        .full    (full_s),
        .empty   (empty_s)
    );

    // Handshake qualification.
    always_comb begin
        push_s = in_valid && !full_s;
        pop_s  = out_ready && !empty_s;
    end

    // Injection next-state; an arm from IDLE never affects the same-cycle push.
    always_comb begin
        inj_state_nxt_s = inj_state_r;
        mask_nxt_s      = mask_r;
        apply_s         = 1'b0;
        case (inj_state_r)
            INJ_IDLE: begin
                if (inj_arm) begin
                    inj_state_nxt_s = INJ_ARMED;
                    mask_nxt_s      = inj_mask;
                end else begin
                    inj_state_nxt_s = INJ_IDLE;
                end
            end
            INJ_ARMED: begin
                if (push_s) begin
                    apply_s         = 1'b1;
                    inj_state_nxt_s = INJ_IDLE;
                end else begin
                    inj_state_nxt_s = INJ_ARMED;
                end
            end
            default: begin
                inj_state_nxt_s = INJ_IDLE;
            end
        endcase
    end

    // Codeword written into the FIFO, with the armed mask folded in.
    always_comb begin
        if (apply_s) begin
            code_s = hamming_encode(in_data) ^ mask_r;
        end else begin
            code_s = hamming_encode(in_data);
        end
    end

    // Injection state and stored mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            inj_state_r <= INJ_IDLE;
            mask_r      <= 8'h00;
        end else begin
            inj_state_r <= inj_state_nxt_s;
            mask_r      <= mask_nxt_s;
        end
    end

    // Accepted-word counter, wrapping modulo 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (push_s) begin
            count_r <= count_r + CNT_W'(1);
        end
    end

    // Outputs are driven from registered FIFO/FSM state only.
    always_comb begin
        in_ready    = !full_s;
        out_valid   = !empty_s;
        inj_pending = (inj_state_r == INJ_ARMED);
        word_count  = count_r;
        if (empty_s) begin
            out_data = 8'h00;
        end else begin
            out_data = head_s;
        end
    end

endmodule

// File: tb/tb_hamming_encoder_stream.sv
// Scoreboard bench for hamming_encoder_stream: directed scenarios plus random
// traffic, checked against a position-based Hamming reference model.
module tb_hamming_encoder_stream;

    localparam int DEPTH = 2;
    localparam int CW    = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_data;
    logic          inj_arm;
    logic [7:0]    inj_mask;
    logic          inj_pending;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_data;
    logic [CW-1:0] word_count;

    int tests = 0;
    int fails = 0;

    logic [7:0]    exp_q[$];
    bit            m_pend = 1'b0;
    logic [7:0]    m_mask = 8'h00;
    logic [CW-1:0] m_cnt  = '0;
    bit            pop_now = 1'b0;
    bit            mon_en = 1'b0;

    hamming_encoder_stream #(
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .inj_arm     (inj_arm),
        .inj_mask    (inj_mask),
        .inj_pending (inj_pending),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .word_count  (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hamming rule by position: parity at 2^k covers positions with bit k set.
    function automatic logic [7:0] ref_encode(input logic [3:0] d);
        logic [7:0] cw;
        int dpos[4] = '{3, 5, 6, 7};
        logic p;
        cw = 8'h00;
        for (int i = 0; i < 4; i++) cw[dpos[i]-1] = d[i];
        for (int k = 0; k < 3; k++) begin
            p = 1'b0;
            for (int pos = 3; pos <= 7; pos++)
                if (((pos >> k) & 1) == 1 && pos != 4) p = p ^ cw[pos-1];
            cw[(1 << k) - 1] = p;
        end
        cw[7] = ($countones(cw[6:0]) % 2) == 1;
        return cw;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every output against the model and pops on handshakes.
    always @(negedge clk) begin
        pop_now = 1'b0;
        if (mon_en && !rst) begin
            chk("out_valid", out_valid, exp_q.size() != 0);
            chk("in_ready", in_ready, exp_q.size() < DEPTH);
            chk("word_count", word_count, m_cnt);
            chk("inj_pending", inj_pending, m_pend);
            if (exp_q.size() == 0) begin
                chk("idle_out_data", out_data, 8'h00);
            end else if (out_ready) begin
                chk("pop_data", out_data, exp_q.pop_front());
                pop_now = 1'b1;
            end
        end
    end

    // Reference model: predicts the effect of the coming clock edge.
    always @(negedge clk) begin
        int occ;
        logic [7:0] w;
        #1;
        if (rst) begin
            exp_q.delete();
            m_pend = 1'b0;
            m_mask = 8'h00;
            m_cnt  = '0;
        end else begin
            occ = exp_q.size() + (pop_now ? 1 : 0);
            if (in_valid && occ < DEPTH) begin
                w = ref_encode(in_data);
                if (m_pend) begin
                    w = w ^ m_mask;
                    m_pend = 1'b0;
                end else if (inj_arm) begin
                    m_pend = 1'b1;
                    m_mask = inj_mask;
                end
                exp_q.push_back(w);
                m_cnt = m_cnt + 1'b1;
            end else if (!m_pend && inj_arm) begin
                m_pend = 1'b1;
                m_mask = inj_mask;
            end
        end
    end

    task automatic check_reset_state(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_out_data"}, out_data, 8'h00);
        chk({tag, "_inj_pending"}, inj_pending, 1'b0);
        chk({tag, "_word_count"}, word_count, 4'h0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 4'h0;
        inj_arm = 1'b0; inj_mask = 8'h00; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check_reset_state("reset");
        mon_en = 1'b1;

        // Encode table at full throughput; 16 pushes wrap the 4-bit counter.
        out_ready = 1'b1;
        for (int v = 0; v < 16; v++) begin
            in_valid = 1'b1; in_data = v[3:0];
            tick();
            if (v == 0)  chk("enc_0", out_data, 8'h00);
            if (v == 1)  chk("enc_1", out_data, 8'h87);
            if (v == 11) chk("enc_B", out_data, 8'h55);
            if (v == 15) chk("enc_F", out_data, 8'hFF);
            chk("enc_parity", ^out_data, 1'b0);
        end
        chk("count_wrap", word_count, 4'h0);
        in_valid = 1'b0;
        tick(); tick();

        // Latency, ordering and backpressure.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 4'hB;
        tick();
        chk("lat_valid", out_valid, 1'b1);
        chk("lat_data", out_data, 8'h55);
        in_data = 4'h1;
        tick();
        chk("full_ready", in_ready, 1'b0);
        chk("lat_count", word_count, 4'h2);
        in_data = 4'h5; out_ready = 1'b1;
        tick();
        chk("full_pop_head", out_data, 8'h87);
        chk("full_pop_ready", in_ready, 1'b1);
        chk("full_no_push", word_count, 4'h2);
        in_valid = 1'b0;
        tick();

        // Injection: arm, re-arm ignored, applied once.
        inj_arm = 1'b1; inj_mask = 8'h04;
        tick();
        inj_arm = 1'b0;
        chk("arm_pending", inj_pending, 1'b1);
        inj_arm = 1'b1; inj_mask = 8'hFF;
        tick();
        inj_arm = 1'b0;
        chk("rearm_pending", inj_pending, 1'b1);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 4'hB;
        tick();
        chk("inj_data", out_data, 8'h51);
        chk("inj_consumed", inj_pending, 1'b0);
        out_ready = 1'b1;
        tick();
        chk("post_inj_data", out_data, 8'h55);
        in_valid = 1'b0;
        tick();

        // Arm in the same cycle as a push: that push is clean, the next one is hit.
        out_ready = 1'b0; inj_arm = 1'b1; inj_mask = 8'h81;
        in_valid = 1'b1; in_data = 4'hF;
        tick();
        inj_arm = 1'b0;
        chk("same_cyc_data", out_data, 8'hFF);
        chk("same_cyc_pending", inj_pending, 1'b1);
        tick();
        chk("same_cyc_full", in_ready, 1'b0);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("same_cyc_next", out_data, 8'h7E);
        tick();

        // Zero mask arms and consumes without altering data.
        inj_arm = 1'b1; inj_mask = 8'h00;
        tick();
        inj_arm = 1'b0; in_valid = 1'b1; in_data = 4'h3;
        tick();
        in_valid = 1'b0;
        chk("zero_mask_data", out_data, 8'h1E);
        chk("zero_mask_pending", inj_pending, 1'b0);
        tick();

        // Random traffic, including occasional resets.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 2) != 0);
            inj_arm   = ($urandom_range(0, 7) == 0);
            inj_mask  = 8'($urandom_range(0, 255));
            rst       = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 1'b0; inj_arm = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick(); tick();

        // Reset mid-stream flushes buffered words and the armed injection.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 4'h6;
        tick();
        in_data = 4'h9;
        tick();
        in_valid = 1'b0; inj_arm = 1'b1; inj_mask = 8'h10;
        tick();
        inj_arm = 1'b0;
        chk("pre_rst_pending", inj_pending, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("mid_rst");
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
